cpu_boot_ctrl: RTL and testbench
================================

# cpu_boot_ctrl

Run controller for the Hack-style `cpu`: it loads a program into instruction ROM from a byte stream, holds the CPU in reset during the load, releases it, then supervises execution and stops it on a terminal condition. It sits between a host byte link (UART/SPI bridge) and the `cpu`'s `reset` and `pc` pins and the ROM write port. It is the only agent that writes ROM.

## Interface
- `ADDR_W`, 15: ROM address width; maximum program length 2^ADDR_W words.
- `CNT_W`, 32: width of the cycle counter and of the cycle limit.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a load.
- `s_valid` in 1, `s_data` in 8, `s_ready` out 1: host byte stream; a byte transfers when `s_valid && s_ready` at a rising edge.
- `rom_we` out 1, `rom_addr` out ADDR_W, `rom_wdata` out 16: registered ROM write port.
- `cpu_rst` out 1: active-high reset driven to the `cpu`.
- `cpu_pc` in 16: the `cpu`'s `pc` output.
- `cycle_limit` in CNT_W: maximum run length; 0 means unlimited.
- `cycles` out CNT_W: number of cycles executed in the current or most recent run.
- `state` out 3: encoded FSM state.
- `done` out 1, `err` out 1, `cause` out 2: halt status.

## Operation
- Stream format, big-endian:
  - Length L: 2 bytes, high byte then low byte.
  - L words: each sent as high byte then low byte.
- States:
  - IDLE=0, LEN_HI=1, LEN_LO=2, DATA_HI=3, DATA_LO=4, RUN=5, HALT=6.
  - `s_ready` is 1 only in LEN_HI to DATA_LO.
- Load sequence:
  - IDLE or HALT + `start` → LEN_HI. This clears `done`, `err`, `cause` and `cycles`, and resets the word index to 0.
  - In LEN_LO, if the assembled L is 0 or L > 2^ADDR_W: go to IDLE, set `err`=1, and discard the byte.
  - DATA_HI latches the high byte. DATA_LO accepts the low byte, which schedules one ROM write.
  - After each word the controller increments the word index and returns to DATA_HI, or goes to RUN after word L.
- Run:
  - `cpu_rst`=0 only in RUN.
  - `cycles` increments every RUN cycle and saturates at all-ones.
- Halt causes, checked every RUN cycle, first match in this order:
  - `cpu_pc` ≥ L (zero-extended compare), ran off the end: `cause`=1.
  - `cycle_limit`≠0 and `cycles`+1 == `cycle_limit`: `cause`=2.
  - Loop detect (see Configuration): `cause`=3.
- On a halt: enter HALT, `done`=1, `cpu_rst`=1. `cycles` freezes with the halting cycle included.
- `start` outside IDLE/HALT is ignored.
- ROM contents are never cleared by the controller.

## Timing
- Reset values:
  - `state`=IDLE, `cpu_rst`=1, `s_ready`=0, `rom_we`=0, `rom_addr`=0, `rom_wdata`=0.
  - `cycles`=0, `done`=0, `err`=0, `cause`=0.
- Asserting `reset` at any point, including mid-load or mid-run, applies these values immediately and asynchronously. Reset release is synchronous to `clk`.
- ROM write:
  - The edge that accepts the DATA_LO byte sets `rom_we`=1 for exactly one cycle on the next cycle.
  - During that cycle `rom_addr`=word index and `rom_wdata`={hi,lo}.
- RUN entry:
  - RUN is entered at the edge that ends the last `rom_we` cycle, so the final write completes before `cpu_rst` falls.
  - The `cpu` fetches address 0 on the first RUN cycle.
- Halt timing: the halt condition is sampled at a RUN edge. `state`=HALT and `cpu_rst`=1 are visible on the next cycle, so the `cpu` executes no further instruction.
- Throughput: one byte per cycle when `s_valid` is held high. L words take 2L+2 accepted bytes.
- Back-pressure: stalls on `s_valid`=0 are unlimited and have no timeout.

## Configuration
- `CPU_BOOT_LOOP_DETECT_EN`
- Defined:
  - The controller keeps the last two `cpu_pc` samples.
  - If `cpu_pc` equals the sample from two cycles earlier on 4 consecutive RUN cycles, it halts with `cause`=3. This catches the `(END) @END; 0;JMP` idiom, whose PC alternates END, END+1.
  - The history and the streak count are cleared on entering RUN.
- Undefined: no history registers exist, and `cause`=3 never occurs.

## Test plan
- Load L=2 with words 0x0005 and 0xEC10, sending bytes at full rate → two `rom_we` pulses at addresses 0 and 1 with exactly those data; RUN is entered the cycle after the second pulse; `cpu_rst` falls in that same cycle.
- In RUN, drive `cpu_pc`=0,1,2 with L=2 → HALT is visible the cycle after `cpu_pc`=2 is sampled, with `cause`=1, `done`=1, `cycles`=3.
- Set `cycle_limit`=10 and hold `cpu_pc`=0 → HALT with `cause`=2 and `cycles`=10.
- Send a length of 0x0000, and separately 0x8001 with ADDR_W=15 → back to IDLE with `err`=1 and no `rom_we`; a subsequent `start` clears `err`.
- Deassert `s_valid` for 7 cycles between the high and low bytes of a word, then assert `reset` in the middle of the third word → no write until the low byte arrives; after `reset`, all outputs show their reset values and `cpu_rst`=1.
- With `CPU_BOOT_LOOP_DETECT_EN` defined, drive `cpu_pc`=4,5,4,5,4,5 with L=8 → HALT with `cause`=3 after the 4th matching cycle. With it undefined, the same stimulus does not halt.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl
//
// Run controller for the Hack-style cpu. It receives a program over a
// big-endian byte stream (2-byte length L, then L 16-bit words, high byte
// first). It writes the words into instruction ROM while the cpu is held in
// reset, then releases the cpu. It stops the cpu when one of these happens:
//   - the PC runs off the end of the program,
//   - the cycle limit is reached,
//   - (optionally) the PC is caught in a two-instruction loop.
//
// Optional feature macro: CPU_BOOT_LOOP_DETECT_EN
//   If it is defined, a 2-deep PC history detects the "(END) @END; 0;JMP"
//   idiom and halts with cause 3. If it is undefined, no history exists.
//
// Parameters
//   ADDR_W       ROM address width (program length limit is 2^ADDR_W words)
//   CNT_W        cycle counter / cycle limit width
//
// Ports
//   clk          single clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse; starts a load from IDLE or HALT
//   s_valid      host byte stream: byte valid
//   s_data       host byte stream: byte value
//   s_ready      host byte stream: controller ready (registered)
//   rom_we       ROM write port (registered): write enable
//   rom_addr     ROM write port (registered): address
//   rom_wdata    ROM write port (registered): data
//   cpu_rst      active-high reset to the cpu; low only while running
//   cpu_pc       cpu program counter
//   cycle_limit  maximum run length, 0 = unlimited
//   cycles       cycles executed in the current / most recent run
//   state        encoded FSM state (IDLE=0 .. HALT=6)
//   done         halt status: run finished
//   err          halt status: the load was rejected
//   cause        halt status: 1 = ran off end, 2 = cycle limit, 3 = loop
// ---------------------------------------------------------------------------
module cpu_boot_ctrl #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_rst,
  input  logic [15:0]       cpu_pc,
  input  logic [CNT_W-1:0]  cycle_limit,
  output logic [CNT_W-1:0]  cycles,
  output logic [2:0]        state,
  output logic              done,
  output logic              err,
  output logic [1:0]        cause
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_RUN     = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  // Largest legal program length, 2^ADDR_W. It is held in a wide constant so
  // that the compare against the 16-bit length field works for any ADDR_W.
  localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_W;

  state_t              state_reg;
  logic                s_ready_reg;
  logic                rom_we_reg;
  logic [ADDR_W-1:0]   rom_addr_reg;
  logic [15:0]         rom_wdata_reg;
  logic                cpu_rst_reg;
  logic [CNT_W-1:0]    cycles_reg;
  logic                done_reg;
  logic                err_reg;
  logic [1:0]          cause_reg;

  logic [7:0]          len_hi_reg;
  logic [15:0]         len_reg;
  logic [7:0]          data_hi_reg;
  logic [ADDR_W-1:0]   word_idx_reg;
  // Set during the ROM write cycle of the final word. The FSM stays in
  // DATA_LO with s_ready low for that one cycle. RUN then begins only after
  // the last word has been written.
  logic                last_wr_reg;

  logic                xfer;
  logic [15:0]         len_asm;
  logic                len_bad;
  logic [ADDR_W-1:0]   last_idx;
  logic                last_word;
  logic [CNT_W-1:0]    cycles_inc;
  logic [CNT_W-1:0]    cycles_sat;
  logic                halt_off_end;
  logic                halt_limit;
  logic                loop_hit;

  assign xfer      = s_valid && s_ready_reg;
  assign len_asm   = {len_hi_reg, s_data};
  assign len_bad   = (len_asm == 16'd0) || ({17'd0, len_asm} > MAX_LEN);
  assign last_idx  = ADDR_W'(len_reg - 16'd1);
  assign last_word = (word_idx_reg == last_idx);

  // When cycles is all-ones, cycles_inc wraps to 0. That value can never
  // equal a non-zero limit, so the saturated counter cannot raise a false
  // limit halt.
  assign cycles_inc   = cycles_reg + CNT_W'(1);
  assign cycles_sat   = (&cycles_reg) ? cycles_reg : cycles_inc;
  assign halt_off_end = (cpu_pc >= len_reg);
  assign halt_limit   = (cycle_limit != '0) && (cycles_inc == cycle_limit);

`ifdef CPU_BOOT_LOOP_DETECT_EN
  logic [15:0] pc_d1_reg;
  logic [15:0] pc_d2_reg;
  logic [1:0]  hist_cnt_reg;   // number of valid history samples, max 2
  logic [1:0]  streak_reg;     // consecutive cycles where pc == pc two cycles ago
  logic        pc_match;

  assign pc_match = (hist_cnt_reg == 2'd2) && (cpu_pc == pc_d2_reg);
  // The current cycle is the 4th match in a row.
  assign loop_hit = pc_match && (streak_reg == 2'd3);

  // The history is held clear outside RUN, so every run starts with an
  // empty history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_d1_reg    <= 16'd0;
      pc_d2_reg    <= 16'd0;
      hist_cnt_reg <= 2'd0;
      streak_reg   <= 2'd0;
    end else if (state_reg != ST_RUN) begin
      pc_d1_reg    <= 16'd0;
      pc_d2_reg    <= 16'd0;
      hist_cnt_reg <= 2'd0;
      streak_reg   <= 2'd0;
    end else begin
      pc_d2_reg  <= pc_d1_reg;
      pc_d1_reg  <= cpu_pc;
      if (hist_cnt_reg != 2'd2) begin
        hist_cnt_reg <= hist_cnt_reg + 2'd1;
      end
      streak_reg <= pc_match ? (streak_reg + 2'd1) : 2'd0;
    end
  end
`else
  assign loop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      s_ready_reg   <= 1'b0;
      rom_we_reg    <= 1'b0;
      rom_addr_reg  <= '0;
      rom_wdata_reg <= 16'd0;
      cpu_rst_reg   <= 1'b1;
      cycles_reg    <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cause_reg     <= 2'd0;
      len_hi_reg    <= 8'd0;
      len_reg       <= 16'd0;
      data_hi_reg   <= 8'd0;
      word_idx_reg  <= '0;
      last_wr_reg   <= 1'b0;
    end else begin
      // rom_we is a single-cycle pulse unless a low byte is accepted below.
      rom_we_reg <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_reg    <= ST_LEN_HI;
            s_ready_reg  <= 1'b1;
            cpu_rst_reg  <= 1'b1;
            cycles_reg   <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            cause_reg    <= 2'd0;
            word_idx_reg <= '0;
            last_wr_reg  <= 1'b0;
          end
        end

        ST_LEN_HI: begin
          if (xfer) begin
            len_hi_reg <= s_data;
            state_reg  <= ST_LEN_LO;
          end
        end

        ST_LEN_LO: begin
          if (xfer) begin
            if (len_bad) begin
              // The load is rejected. The low byte is consumed and dropped.
              state_reg   <= ST_IDLE;
              s_ready_reg <= 1'b0;
              err_reg     <= 1'b1;
            end else begin
              len_reg   <= len_asm;
              state_reg <= ST_DATA_HI;
            end
          end
        end

        ST_DATA_HI: begin
          if (xfer) begin
            data_hi_reg <= s_data;
            state_reg   <= ST_DATA_LO;
          end
        end

        ST_DATA_LO: begin
          if (last_wr_reg) begin
            // The final ROM write happens in this cycle. cpu_rst is released
            // at the edge that ends it.
            last_wr_reg <= 1'b0;
            state_reg   <= ST_RUN;
            cpu_rst_reg <= 1'b0;
          end else if (xfer) begin
            rom_we_reg    <= 1'b1;
            rom_addr_reg  <= word_idx_reg;
            rom_wdata_reg <= {data_hi_reg, s_data};
            word_idx_reg  <= word_idx_reg + ADDR_W'(1);
            if (last_word) begin
              last_wr_reg <= 1'b1;
              s_ready_reg <= 1'b0;
            end else begin
              state_reg <= ST_DATA_HI;
            end
          end
        end

        ST_RUN: begin
          // The halting cycle itself is counted.
          cycles_reg <= cycles_sat;
          if (halt_off_end || halt_limit || loop_hit) begin
            state_reg   <= ST_HALT;
            cpu_rst_reg <= 1'b1;
            done_reg    <= 1'b1;
            if (halt_off_end) begin
              cause_reg <= 2'd1;
            end else if (halt_limit) begin
              cause_reg <= 2'd2;
            end else begin
              cause_reg <= 2'd3;
            end
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          s_ready_reg <= 1'b0;
          cpu_rst_reg <= 1'b1;
          last_wr_reg <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_reg;
  assign s_ready   = s_ready_reg;
  assign rom_we    = rom_we_reg;
  assign rom_addr  = rom_addr_reg;
  assign rom_wdata = rom_wdata_reg;
  assign cpu_rst   = cpu_rst_reg;
  assign cycles    = cycles_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign cause     = cause_reg;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_boot_ctrl
//
// Self-checking bench for cpu_boot_ctrl. It runs directed loads and runs,
// then randomized ones. Expected ROM writes come from the program words. The
// expected halt cycle and cause come from a reference model that scans the
// driven PC sequence against the halt rules. Inputs are driven and outputs
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_boot_ctrl;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 32;
`ifdef CPU_BOOT_LOOP_DETECT_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_rst;
  logic [15:0]       cpu_pc = 16'd0;
  logic [CNT_W-1:0]  cycle_limit = '0;
  logic [CNT_W-1:0]  cycles;
  logic [2:0]        state;
  logic              done;
  logic              err;
  logic [1:0]        cause;

  always #5 clk = ~clk;

  cpu_boot_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_rst(cpu_rst), .cpu_pc(cpu_pc), .cycle_limit(cycle_limit),
    .cycles(cycles), .state(state), .done(done), .err(err), .cause(cause)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;   // total rom_we cycles observed

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rom_we === 1'b1) wr_cnt++;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_state"}, state, 0);
    check_val({tag, "_cpu_rst"}, cpu_rst, 1);
    check_val({tag, "_s_ready"}, s_ready, 0);
    check_val({tag, "_rom_we"}, rom_we, 0);
    check_val({tag, "_rom_addr"}, rom_addr, 0);
    check_val({tag, "_rom_wdata"}, rom_wdata, 0);
    check_val({tag, "_cycles"}, cycles, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_err"}, err, 0);
    check_val({tag, "_cause"}, cause, 0);
  endtask

  // Asynchronous reset pulse. The values are checked before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_reset_vals(tag);
    tick();
    reset = 1'b1;
    tick();
    check_val({tag, "_post_state"}, state, 0);
    $display("reset %s", tag);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_state", state, 1);
    check_val("start_s_ready", s_ready, 1);
    check_val("start_done", done, 0);
    check_val("start_err", err, 0);
    check_val("start_cause", cause, 0);
    check_val("start_cycles", cycles, 0);
    check_val("start_cpu_rst", cpu_rst, 1);
  endtask

  // Idle gap cycles, which may carry stray start pulses. Then one byte is
  // transferred at the next edge.
  task automatic send_byte(input string tag, input logic [7:0] b, input int gap, input bit noise);
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      start   = noise && ($urandom_range(0, 1) == 1);
      tick();
      start   = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = b;
    check_val(tag, s_ready, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [15:0] w, input int gap_hi,
                           input int gap_lo, input bit noise);
    send_byte("s_ready_dhi", w[15:8], gap_hi, noise);
    send_byte("s_ready_dlo", w[7:0], gap_lo, noise);
    check_val("wr_we", rom_we, 1);
    check_val("wr_addr", rom_addr, 64'(idx));
    check_val("wr_data", rom_wdata, w);
  endtask

  task automatic do_load(input int len, input logic [15:0] words[$], input int max_gap,
                         input bit noise);
    int w0;
    logic [15:0] len16;
    len16 = 16'(len);
    do_start();
    w0 = wr_cnt;
    send_byte("s_ready_lhi", len16[15:8], $urandom_range(0, max_gap), noise);
    send_byte("s_ready_llo", len16[7:0], $urandom_range(0, max_gap), noise);
    for (int i = 0; i < len; i++) begin
      send_word(i, words[i], $urandom_range(0, max_gap), $urandom_range(0, max_gap), noise);
    end
    check_val("last_wr_cpu_rst", cpu_rst, 1);
    tick();
    check_val("run_entry_state", state, 5);
    check_val("run_entry_cpu_rst", cpu_rst, 0);
    check_val("run_entry_rom_we", rom_we, 0);
    check_val("load_wr_count", 64'(wr_cnt - w0), 64'(len));
    $display("load L=%0d max_gap=%0d writes=%0d", len, max_gap, wr_cnt - w0);
  endtask

  // Reference model: scan the PC sequence with the halt rules in priority
  // order. Then drive it one PC per cycle and compare.
  task automatic do_run(input int len, input logic [15:0] pcs[$], input logic [31:0] limit);
    int halt_k;
    int exp_cause;
    int streak;
    halt_k    = -1;
    exp_cause = 0;
    streak    = 0;
    for (int k = 0; k < pcs.size(); k++) begin
      if (int'(pcs[k]) >= len) begin
        exp_cause = 1; halt_k = k; break;
      end
      if (limit != 0 && 32'(k + 1) == limit) begin
        exp_cause = 2; halt_k = k; break;
      end
      if (LOOP_EN) begin
        if (k >= 2 && pcs[k] == pcs[k-2]) streak++;
        else streak = 0;
        if (streak == 4) begin
          exp_cause = 3; halt_k = k; break;
        end
      end
    end

    cycle_limit = limit;
    for (int k = 0; k <= halt_k; k++) begin
      cpu_pc = pcs[k];
      tick();
      if (k < halt_k) begin
        check_val("run_state", state, 5);
        check_val("run_cycles", cycles, 64'(k + 1));
        if (state != 3'd5) break;
      end else begin
        check_val("halt_state", state, 6);
        check_val("halt_cpu_rst", cpu_rst, 1);
        check_val("halt_done", done, 1);
        check_val("halt_cause", cause, 64'(exp_cause));
        check_val("halt_cycles", cycles, 64'(halt_k + 1));
      end
    end
    repeat (2) begin
      cpu_pc = 16'($urandom_range(0, 3));
      tick();
    end
    check_val("frozen_state", state, 6);
    check_val("frozen_cycles", cycles, 64'(halt_k + 1));
    $display("run L=%0d limit=%0d halt_cycle=%0d cause=%0d", len, limit, halt_k + 1, exp_cause);
  endtask

  task automatic do_bad_len(input logic [15:0] len16);
    int w0;
    do_start();
    w0 = wr_cnt;
    send_byte("s_ready_lhi", len16[15:8], 0, 1'b0);
    send_byte("s_ready_llo", len16[7:0], 0, 1'b0);
    check_val("badlen_state", state, 0);
    check_val("badlen_err", err, 1);
    check_val("badlen_s_ready", s_ready, 0);
    check_val("badlen_done", done, 0);
    repeat (3) tick();
    check_val("badlen_no_wr", 64'(wr_cnt - w0), 0);
    check_val("badlen_err_hold", err, 1);
    $display("bad length 0x%04h rejected", len16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words[$];
    logic [15:0] pcs[$];
    int w0;
    int len;
    logic [31:0] limit;

    // Power-on reset
    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b1;
    tick();
    check_val("por_release_state", state, 0);

    // L=2 at full rate, then run off the end at pc=2
    words = '{16'h0005, 16'hEC10};
    do_load(2, words, 0, 1'b0);
    pcs = '{16'd0, 16'd1, 16'd2};
    do_run(2, pcs, 32'd0);

    // Cycle limit of 10 while pc is held at 0
    words = '{16'h1111, 16'h2222, 16'h3333};
    do_load(3, words, 1, 1'b1);
    pcs.delete();
    repeat (20) pcs.push_back(16'd0);
    pcs.push_back(16'd3);
    do_run(3, pcs, 32'd10);

    // Illegal lengths. The following start clears err.
    do_bad_len(16'h0000);
    do_bad_len(16'h8001);

    // L = 2^ADDR_W is the largest legal length and must be accepted
    do_start();
    send_byte("s_ready_lhi", 8'h80, 0, 1'b0);
    send_byte("s_ready_llo", 8'h00, 0, 1'b0);
    check_val("maxlen_state", state, 3);
    check_val("maxlen_err", err, 0);
    do_reset("maxlen_rst");

    // Stall between the bytes of a word, then reset in the middle of word 2
    words.delete();
    repeat (4) words.push_back(16'($urandom));
    do_start();
    w0 = wr_cnt;
    send_byte("s_ready_lhi", 8'h00, 0, 1'b0);
    send_byte("s_ready_llo", 8'h04, 0, 1'b0);
    send_byte("s_ready_dhi", words[0][15:8], 0, 1'b0);
    for (int g = 0; g < 7; g++) begin
      tick();
      check_val("stall_rom_we", rom_we, 0);
    end
    send_byte("s_ready_dlo", words[0][7:0], 0, 1'b0);
    check_val("stall_wr_we", rom_we, 1);
    check_val("stall_wr_addr", rom_addr, 0);
    check_val("stall_wr_data", rom_wdata, words[0]);
    send_word(1, words[1], 0, 0, 1'b0);
    send_byte("s_ready_dhi", words[2][15:8], 0, 1'b0);
    check_val("midload_wr_count", 64'(wr_cnt - w0), 2);
    do_reset("midload_rst");

    // Loop pattern 4,5,4,5,...; ends at pc=L if no loop halt happens
    words.delete();
    repeat (8) words.push_back(16'($urandom));
    do_load(8, words, 0, 1'b0);
    pcs.delete();
    repeat (5) begin
      pcs.push_back(16'd4);
      pcs.push_back(16'd5);
    end
    pcs.push_back(16'd8);
    do_run(8, pcs, 32'd0);

    // Randomized loads and runs, each starting from HALT
    for (int it = 0; it < 8; it++) begin
      // Bytes offered before start must be ignored
      s_valid = 1'b1;
      repeat (2) begin
        s_data = 8'($urandom);
        tick();
      end
      s_valid = 1'b0;
      check_val("halt_ignores_bytes", state, 6);

      len = $urandom_range(1, 12);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back(16'($urandom));
      do_load(len, words, $urandom_range(0, 3), 1'b1);

      limit = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 40)) : 32'd0;
      pcs.delete();
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 59; i++) pcs.push_back(16'((i % 2 == 0) ? 0 : len - 1));
      end else begin
        for (int i = 0; i < 59; i++) begin
          if ($urandom_range(0, 19) == 0) pcs.push_back(16'($urandom_range(len, len + 5)));
          else pcs.push_back(16'($urandom_range(0, len - 1)));
        end
      end
      pcs.push_back(16'(len));
      do_run(len, pcs, limit);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
